// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the fetch/LSU memory arbiter: FSM states, grant encoding, counter width.
package riscv_mem_arb_pkg;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {GNT_IF = 1'b0, GNT_D = 1'b1} gnt_e;
endpackage

// File: rtl/riscv_mem_arb_prio.sv
// Winner selection between fetch and data: data first, fetch forced after STARVE_MAX losses.
module riscv_mem_arb_prio
  import riscv_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid_i,
  input  logic d_valid_i,
  input  logic arb_en_i,
  output logic gnt_o,
  output logic if_ready_o,
  output logic d_ready_o
);
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             force_if, pick_d, en;

  always_comb begin
    force_if   = if_valid_i && (starve_q == CNT_W'(STARVE_MAX));
    pick_d     = d_valid_i && !force_if;
    gnt_o      = pick_d ? GNT_D : GNT_IF;
    // readies are held low while reset is asserted, independent of state
    en         = arb_en_i && rst_n;
    d_ready_o  = en && pick_d;
    if_ready_o = en && if_valid_i && !pick_d;
    starve_d   = starve_q;
    if (if_ready_o)
      starve_d = '0;
    else if (d_ready_o && if_valid_i && (starve_q != CNT_W'(STARVE_MAX)))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter for a fixed-latency unified memory shared by fetch and LSU.
module riscv_mem_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                d_req_valid,
  input  logic                d_req_we,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  output logic                d_req_ready,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);
  state_e              state_q;
  logic                gnt, gnt_q, we_q, acc;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_en_q, mem_we_q, if_rsp_valid_q, d_rsp_valid_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rsp_data_q, d_rsp_data_q;
  logic [DATA_W/8-1:0] mem_wstrb_q;

  riscv_mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid_i (if_req_valid),
    .d_valid_i  (d_req_valid),
    .arb_en_i   (state_q == IDLE),
    .gnt_o      (gnt),
    .if_ready_o (if_req_ready),
    .d_ready_o  (d_req_ready)
  );

  assign acc = (if_req_valid && if_req_ready) || (d_req_valid && d_req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      gnt_q          <= GNT_IF;
      we_q           <= 1'b0;
      cnt_q          <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= '0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_data_q   <= '0;
    end else begin
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      case (state_q)
        IDLE: if (acc) begin
          // access fields are registered here so they appear with mem_en in ISSUE
          gnt_q       <= gnt;
          we_q        <= (gnt == GNT_D) && d_req_we;
          mem_en_q    <= 1'b1;
          mem_we_q    <= (gnt == GNT_D) && d_req_we;
          mem_addr_q  <= (gnt == GNT_D) ? d_req_addr : if_req_addr;
          mem_wdata_q <= (gnt == GNT_D) ? d_req_wdata : '0;
          mem_wstrb_q <= (gnt == GNT_D) ? d_req_wstrb : '0;
          state_q     <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= CNT_W'(MEM_LAT);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == CNT_W'(1)) begin
          if (gnt_q == GNT_D) begin
            d_rsp_valid_q <= 1'b1;
            d_rsp_data_q  <= we_q ? '0 : mem_rdata;
          end else begin
            if_rsp_valid_q <= 1'b1;
            if_rsp_data_q  <= mem_rdata;
          end
          state_q <= RESP;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_wstrb    = mem_wstrb_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a fixed-latency memory model and a response scoreboard.
module tb_riscv_mem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr = '0, if_rsp_data;
  logic        d_req_valid = 1'b0, d_req_we = 1'b0, d_req_ready, d_rsp_valid;
  logic [31:0] d_req_addr = '0, d_req_wdata = '0, d_rsp_data;
  logic [3:0]  d_req_wstrb = '0;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'hBAD0BAD0;
  logic [3:0]  mem_wstrb;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mexp_t;

  typedef struct packed {
    int unsigned cyc;
    logic        is_if;
    logic        is_d;
    logic [31:0] data;
  } rexp_t;

  mexp_t       mq[$];
  rexp_t       rq[$];
  logic [31:0] mem_m [logic [31:0]];
  int unsigned cyc = 0;
  int          checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return ~a ^ 32'h1234_0000;
  endfunction

  function automatic void wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_m[a] = w;
  endfunction

  // fixed-latency memory: word for a mem_en cycle is on mem_rdata LAT cycles later
  logic        p1_v = 1'b0;
  logic [31:0] p1_d = '0;
  always @(posedge clk) begin
    p1_v      <= mem_en;
    p1_d      <= rd(mem_addr);
    mem_rdata <= p1_v ? p1_d : 32'hBAD0BAD0;
  end

  // acceptance -> scoreboard push; mem_en and responses -> pop and compare
  always @(negedge clk) begin
    mexp_t mo, me;
    rexp_t ro, re;
    #2;
    chk("one_ready", {if_req_ready, d_req_ready} == 2'b11, 1'b0);
    if (if_req_valid && if_req_ready) begin
      mq.push_back('{cyc + 1, 1'b0, if_req_addr, 32'd0, 4'd0});
      rq.push_back('{cyc + 2 + LAT, 1'b1, 1'b0, rd(if_req_addr)});
    end
    if (d_req_valid && d_req_ready) begin
      mq.push_back('{cyc + 1, d_req_we, d_req_addr, d_req_wdata, d_req_wstrb});
      rq.push_back('{cyc + 2 + LAT, 1'b0, 1'b1, d_req_we ? 32'd0 : rd(d_req_addr)});
      if (d_req_we) wr(d_req_addr, d_req_wdata, d_req_wstrb);
    end
    if (mem_en) begin
      mo = '{cyc, mem_we, mem_addr, mem_wdata, mem_wstrb};
      if (mq.size() == 0) chk("mem_en_unexpected", mo, '0);
      else begin
        me = mq.pop_front();
        chk("mem_access", mo, me);
      end
    end
    if (if_rsp_valid || d_rsp_valid) begin
      ro = '{cyc, if_rsp_valid, d_rsp_valid, if_rsp_valid ? if_rsp_data : d_rsp_data};
      if (rq.size() == 0) chk("rsp_unexpected", ro, '0);
      else begin
        re = rq.pop_front();
        chk("rsp", ro, re);
      end
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while ((mq.size() != 0 || rq.size() != 0) && k < 40) begin
      @(negedge clk); #3;
      k++;
    end
    chk("drain_timeout", k < 40, 1'b1);
  endtask

  task automatic go_if(input logic [31:0] a);
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = a;
    #1 chk("if_grant", {if_req_ready, d_req_ready}, 2'b10);
    @(negedge clk);
    if_req_valid = 1'b0;
    drain();
  endtask

  task automatic go_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = a; d_req_wdata = wd; d_req_wstrb = ws;
    #1 chk("d_grant", {if_req_ready, d_req_ready}, 2'b01);
    @(negedge clk);
    d_req_valid = 1'b0;
    drain();
  endtask

  // both requesters held valid; pat bit g set means grant g must go to fetch
  task automatic held_seq(input int n, input logic [15:0] pat, input logic [31:0] ia, input logic [31:0] da);
    int w;
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = ia;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = da; d_req_wdata = '0; d_req_wstrb = '0;
    for (int g = 0; g < n; g++) begin
      w = 0;
      #1;
      while (!(if_req_ready || d_req_ready) && w < 10) begin
        @(negedge clk); #1;
        w++;
      end
      chk("grant_order", {if_req_ready, d_req_ready}, pat[g] ? 2'b10 : 2'b01);
      if (g > 0) chk("grant_gap", w, 4);
      @(negedge clk);
      if_req_addr = if_req_addr + 4;
      d_req_addr  = d_req_addr + 4;
    end
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    drain();
  endtask

  initial begin
    mem_m[32'h100] = 32'h00500093;
    mem_m[32'h104] = 32'h00100113;

    // reset state with both requests pending
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    chk("rst_ready", {if_req_ready, d_req_ready}, 2'b00);
    chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, '0);
    chk("rst_rsp", {if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_data}, '0);
    @(negedge clk); @(negedge clk);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    rst_n = 1'b1;

    go_if(32'h100);
    go_d(1'b1, 32'h2000, 32'hDEADBEEF, 4'hF);
    go_d(1'b0, 32'h2000, 32'h0, 4'h0);
    go_d(1'b1, 32'h2000, 32'h11223344, 4'h5);
    go_d(1'b0, 32'h2000, 32'h0, 4'h0);

    // simultaneous fetch + load: data wins, fetch follows at the next IDLE cycle
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h108;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h2000; d_req_wdata = '0; d_req_wstrb = '0;
    #1 chk("simul_grant", {if_req_ready, d_req_ready}, 2'b01);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      if (k == 1) d_req_valid = 1'b0;
      #1 chk("if_wait", if_req_ready, 1'b0);
    end
    @(negedge clk);
    #1 chk("if_late_grant", {if_req_ready, d_req_ready}, 2'b10);
    @(negedge clk);
    if_req_valid = 1'b0;
    drain();

    held_seq(10, 16'h0210, 32'h400, 32'h300);

    // fetch withdrawn during a data transaction must not be granted or counted
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h500;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h600;
    #1 chk("wd_grant", {if_req_ready, d_req_ready}, 2'b01);
    @(negedge clk);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1 chk("wd_no_if", if_req_ready, 1'b0);
    end
    drain();
    for (int i = 0; i < 4; i++) go_d(1'b0, 32'h700 + 32'(4 * i), 32'h0, 4'h0);
    held_seq(4, 16'h0008, 32'h800, 32'h900);

    // reset during WAIT of a load drops it; a fetch after release is normal
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h2000;
    #1 chk("pre_rst_grant", d_req_ready, 1'b1);
    @(negedge clk);
    d_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    mq.delete(); rq.delete();
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    #1;
    chk("midrst_ready", {if_req_ready, d_req_ready}, 2'b00);
    chk("midrst_mem", {mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb}, '0);
    chk("midrst_rsp", {if_rsp_valid, d_rsp_valid, if_rsp_data, d_rsp_data}, '0);
    @(negedge clk);
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    go_if(32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Arbitrates one single-port, fixed-latency memory between the instruction-fetch port and the load/store port of the rv32i core. It sequences each access through a small FSM: accept, issue, wait, respond. It also guarantees forward progress of fetch under sustained data traffic. It sits between the core's fetch/LSU request logic and the unified instruction/data memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte strobes = DATA_W/8)
- MEM_LAT, 2, cycles from the mem_en cycle to the mem_rdata-valid cycle; legal range 1..15
- STARVE_MAX, 4, consecutive fetch arbitration losses before fetch is forced to win; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  one-cycle fetch response pulse
- if_rsp_data  out  DATA_W  fetched word
- d_req_valid  in  1  load/store request
- d_req_we  in  1  1 = store
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_req_wstrb  in  DATA_W/8  store byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_rsp_valid  out  1  one-cycle load data / store ack pulse
- d_rsp_data  out  DATA_W  load data; 0 for store acks
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  write enable
- mem_addr, mem_wdata, mem_wstrb  out  ADDR_W, DATA_W, DATA_W/8  registered access fields
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. One outstanding transaction at a time.
- IDLE: if any valid, grant the winner and pulse its ready combinationally. Acceptance is valid&&ready. At the acceptance edge, latch the request fields and the grant, then go to ISSUE. With no valid, stay in IDLE.
- Winner: data, unless if_req_valid is high and starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt: increments, saturating, on each data grant while if_req_valid is high. Clears on any fetch grant.
- ISSUE: mem_en=1 and mem_we/addr/wdata/wstrb are driven from the latch. Load the wait counter with MEM_LAT, then go to WAIT. For a fetch, mem_we=0 and mem_wstrb=0.
- WAIT: decrement each cycle. In the cycle the counter reads 1, sample mem_rdata into the response register and go to RESP.
- RESP: pulse the granted port's rsp_valid for one cycle. Store acks drive d_rsp_data=0. Return to IDLE. Ready is never asserted outside IDLE.
- Requesters hold valid and fields stable until ready. A valid that drops before ready is legal and simply withdraws the request.
- Responses cannot be back-pressured.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, starve_cnt=0. mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, both rsp_valid and both rsp_data are 0. Both ready outputs are forced to 0 while rst_n is low.
- Acceptance edge E:
  - mem_en high in cycle E+1.
  - mem_rdata sampled at the end of cycle E+1+MEM_LAT.
  - rsp_valid high in cycle E+2+MEM_LAT.
- Next acceptance is possible at the end of cycle E+3+MEM_LAT, giving throughput of 1 transaction per MEM_LAT+3 cycles.
- If reset asserts mid-transaction, the transaction is dropped: no rsp_valid pulse afterwards and no further mem_en. A request presented after reset release is arbitrated normally.
- Simultaneous valids resolve in a single IDLE cycle, and exactly one ready is ever high.
- Counter width: clog2(16) = 4 bits for both counters. The wait counter never wraps; starve_cnt saturates.

## Structure
- Package riscv_mem_arb_pkg: state enum (IDLE/ISSUE/WAIT/RESP), grant encoding (GNT_IF, GNT_D), counter width constant.
- Sub-module riscv_mem_arb_prio: winner selection plus starve_cnt register. Inputs are both valids and an arbitrate-enable; outputs are the grant and both readies.
- The top level holds the FSM, request latch, wait counter and response registers.

## Test plan
All scenarios use MEM_LAT=2 and STARVE_MAX=4.
- Fetch 0x100, memory returns 0x00500093 → mem_en one cycle in E+1 with addr 0x100, we=0 → if_rsp_valid in E+4 with data 0x00500093.
- Store addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF → mem_we=1 with those fields in E+1 → d_rsp_valid in E+4 with d_rsp_data=0, if_rsp_valid stays 0.
- Fetch and load valid in the same cycle → d_req_ready only; fetch accepted at the next IDLE cycle, 5 cycles later.
- Both valids held continuously → grant order D,D,D,D,IF, then repeats; starve_cnt returns to 0 after the IF grant.
- Assert rst_n low during WAIT of a load → all outputs 0 immediately, no d_rsp_valid ever follows; after release a fetch to 0x104 completes with normal E+4 timing.
- Drop if_req_valid during a data transaction → no fetch grant afterwards, and starve_cnt is not incremented for cycles without fetch valid.
